// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and entry type for the writeback queue and its bypass search.
package wb_pkg;
  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int NUM_ARCH_REGS = 32;
  typedef struct packed {
    logic [REGW-1:0] rd_s;
    logic [XLEN-1:0] rd_v;
  } wb_entry_t;
endpackage

// File: rtl/wb_bypass_match.sv
// wb_bypass_match: age-ordered search of queued writebacks; the youngest valid match wins.
module wb_bypass_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries_i,
  input  logic      [DEPTH-1:0] valid_i,
  input  logic      [PW-1:0]    head_i,
  input  logic      [REGW-1:0]  rs_s_i,
  output logic                  hit_o,
  output logic      [XLEN-1:0]  v_o
);
  always_comb begin
    hit_o = 1'b0;
    v_o   = '0;
    // Walk oldest to youngest so later matches overwrite earlier ones.
    for (int i = 0; i < DEPTH; i++) begin
      automatic logic [PW-1:0] idx = head_i + PW'(i);
      if (valid_i[idx] && entries_i[idx].rd_s == rs_s_i && rs_s_i != '0) begin
        hit_o = 1'b1;
        v_o   = entries_i[idx].rd_v;
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback buffer draining into the register file, with rs1/rs2 bypass.
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW = $clog2(DEPTH),
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [REGW-1:0] in_rd_s,
  input  logic [XLEN-1:0] in_rd_v,
  input  logic            wr_grant,
  output logic            regf_we,
  output logic [REGW-1:0] regf_rd_s,
  output logic [XLEN-1:0] regf_rd_v,
  input  logic [REGW-1:0] rs1_s,
  output logic            rs1_hit,
  output logic [XLEN-1:0] rs1_v,
  input  logic [REGW-1:0] rs2_s,
  output logic            rs2_hit,
  output logic [XLEN-1:0] rs2_v,
  output logic [CW-1:0]   count
);
  wb_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic empty, push, pop, h1, h2;
  logic [XLEN-1:0] v1, v2;

  assign empty = count_q == '0;
  assign in_ready = count_q < CW'(DEPTH) && !rst;
  assign regf_we = !empty && wr_grant && !rst;
  // Writes to x0 complete the handshake but are never stored.
  assign push = in_valid && in_ready && in_rd_s != '0;
  assign pop = regf_we;
  assign regf_rd_s = empty ? '0 : mem_q[head_q].rd_s;
  assign regf_rd_v = empty ? '0 : mem_q[head_q].rd_v;
  assign count = count_q;

  always_comb begin
    head_d  = pop ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop) valid_q[head_q] <= 1'b0;
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        mem_q[tail_q]   <= '{rd_s: in_rd_s, rd_v: in_rd_v};
      end
    end
  end

  wb_bypass_match #(.DEPTH(DEPTH)) u_rs1 (
    .entries_i(mem_q), .valid_i(valid_q), .head_i(head_q), .rs_s_i(rs1_s), .hit_o(h1), .v_o(v1)
  );
  wb_bypass_match #(.DEPTH(DEPTH)) u_rs2 (
    .entries_i(mem_q), .valid_i(valid_q), .head_i(head_q), .rs_s_i(rs2_s), .hit_o(h2), .v_o(v2)
  );

  assign rs1_hit = h1 && !rst;
  assign rs1_v   = rst ? '0 : v1;
  assign rs2_hit = h2 && !rst;
  assign rs2_v   = rst ? '0 : v2;
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed and random stimulus checked against a queue-based reference model.
module tb_wb_write_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, wr_grant = 1'b0;
  logic in_ready, regf_we, rs1_hit, rs2_hit;
  logic [4:0] in_rd_s = '0, rs1_s = '0, rs2_s = '0, regf_rd_s;
  logic [31:0] in_rd_v = '0, regf_rd_v, rs1_v, rs2_v;
  logic [2:0] count;
  int checks = 0, failures = 0;

  typedef struct {logic [4:0] rd; logic [31:0] v;} ent_t;
  ent_t q[$];
  logic [31:0] wr_log[$];

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd_s(in_rd_s),
    .in_rd_v(in_rd_v), .wr_grant(wr_grant), .regf_we(regf_we), .regf_rd_s(regf_rd_s),
    .regf_rd_v(regf_rd_v), .rs1_s(rs1_s), .rs1_hit(rs1_hit), .rs1_v(rs1_v), .rs2_s(rs2_s),
    .rs2_hit(rs2_hit), .rs2_v(rs2_v), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] look(input logic [4:0] s);
    if (rst || s == 0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].rd == s) return {1'b1, q[i].v};
    return '0;
  endfunction

  task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] val, input logic g,
                      input logic [4:0] a, input logic [4:0] b, input logic r);
    logic exp_ready, exp_we;
    logic [32:0] l1, l2;
    @(negedge clk);
    in_valid = v; in_rd_s = rd; in_rd_v = val; wr_grant = g; rs1_s = a; rs2_s = b; rst = r;
    #1;
    exp_ready = q.size() < DEPTH && !r;
    exp_we = q.size() > 0 && g && !r;
    l1 = look(a);
    l2 = look(b);
    chk("in_ready", in_ready, exp_ready);
    chk("regf_we", regf_we, exp_we);
    chk("count", count, q.size());
    chk("regf_rd_s", regf_rd_s, q.size() > 0 ? q[0].rd : 5'd0);
    chk("regf_rd_v", regf_rd_v, q.size() > 0 ? q[0].v : 32'd0);
    chk("rs1", {rs1_hit, rs1_v}, l1);
    chk("rs2", {rs2_hit, rs2_v}, l2);
    if (regf_we) wr_log.push_back(regf_rd_v);
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (exp_we) void'(q.pop_front());
      if (v && exp_ready && rd != 0) q.push_back('{rd, val});
    end
  endtask

  task automatic idle(input logic g, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, g, 5, 7, 0);
  endtask

  initial begin
    @(posedge clk);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int s = 0; s < 32; s++) step(0, 0, 0, 0, 5'(s), 5'(s), 0);
    chk("rst_count", count, 0);

    step(1, 5, 32'hDEADBEEF, 0, 5, 0, 0);
    step(0, 0, 0, 0, 5, 0, 0);
    chk("x5_hit_val", {rs1_hit, rs1_v}, {1'b1, 32'hDEADBEEF});
    step(0, 0, 0, 1, 5, 0, 0);
    step(0, 0, 0, 1, 5, 0, 0);
    chk("x5_drained", {regf_we, count, rs1_hit}, 0);
    chk("x5_one_write", wr_log.size(), 1);

    wr_log.delete();
    step(1, 7, 1, 0, 0, 7, 0);
    step(1, 7, 2, 0, 0, 7, 0);
    step(1, 7, 3, 0, 0, 7, 0);
    step(0, 0, 0, 1, 0, 7, 0);
    step(0, 0, 0, 0, 0, 7, 0);
    chk("x7_youngest", rs2_v, 3);
    idle(1, 3);
    chk("x7_order", {wr_log[0], wr_log[1], wr_log[2]}, {32'd1, 32'd2, 32'd3});

    for (int i = 0; i < DEPTH; i++) step(1, 5'(i + 1), 32'(i + 10), 0, 0, 0, 0);
    step(1, 9, 99, 0, 0, 0, 0);
    chk("full_ready", in_ready, 0);
    step(1, 9, 99, 1, 9, 0, 0);
    step(1, 9, 99, 0, 9, 0, 0);
    step(0, 0, 0, 0, 9, 0, 0);
    chk("fifth_accepted", {rs1_hit, rs1_v, count}, {1'b1, 32'd99, 3'd4});
    idle(1, 5);

    step(1, 0, 32'h1234, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("x0_dropped", {count, regf_we, rs1_hit}, 0);

    for (int i = 0; i < 3; i++) step(1, 5'(i + 3), 32'(i + 40), 0, 3, 4, 0);
    step(0, 0, 0, 1, 3, 4, 0);
    wr_log.delete();
    step(0, 0, 0, 1, 4, 5, 1);
    idle(1, 4);
    chk("rst_discard", {count, 32'(wr_log.size())}, 0);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 60) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
